keccak_frame_ctl: RTL and testbench

Frame sequencer between the lane-stream source and the Keccak-f[1600] permutation block, and between the permutation block and the lane-stream sink. It counts lanes into 25-lane frames and forces `firstin` alignment toward the core. It limits the number of frames in flight through the core, re-times both handshakes, and reports alignment errors and frame counts.

---
 rtl/keccak_frame_ctl.sv | 134 +++++++++++++
 tb/tb_keccak_frame_ctl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/keccak_frame_ctl.sv
// Frame sequencer around a Keccak-f[1600] core: counts lanes into frames, forces
// lane-0 alignment toward the core, bounds frames in flight, and re-times both streams.
module keccak_frame_ctl #(
  parameter int W            = 64,
  parameter int LANES        = 25,
  parameter int MAX_INFLIGHT = 1,
  parameter int CW           = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pushin,
  output logic          stopin,
  input  logic          firstin,
  input  logic [W-1:0]  din,
  output logic          p_pushin,
  input  logic          p_stopin,
  output logic          p_firstin,
  output logic [W-1:0]  p_din,
  input  logic          p_pushout,
  output logic          p_stopout,
  input  logic          p_firstout,
  input  logic [W-1:0]  p_dout,
  output logic          pushout,
  input  logic          stopout,
  output logic          firstout,
  output logic [W-1:0]  dout,
  output logic          err_in,
  output logic          err_out,
  output logic [CW-1:0] frames_in,
  output logic [CW-1:0] frames_out,
  output logic          busy
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int FW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);
  localparam logic [FW-1:0] FMAX = FW'(MAX_INFLIGHT);

  // input skid: {firstin, din} entries
  logic [W:0]    fq [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    fcnt, fcnt_nxt;
  logic [LW-1:0] icnt, ocnt;
  logic [FW-1:0] inflight;
  logic          out_valid, out_first;
  logic [W-1:0]  out_data;

  logic in_xfer, core_xfer, pout_xfer, sink_xfer;
  logic gate, head_first, frame_start, frame_done;

  assign in_xfer    = pushin & ~stopin;
  assign core_xfer  = p_pushin & ~p_stopin;
  assign pout_xfer  = p_pushout & ~p_stopout;
  assign sink_xfer  = out_valid & ~stopout;

  assign head_first = fq[rd_ptr][W];
  assign p_din      = fq[rd_ptr][W-1:0];
  assign gate       = (icnt == '0) && (inflight == FMAX);
  assign p_pushin   = (fcnt != 2'd0) && !gate;
  assign p_firstin  = (icnt == '0);

  assign frame_start = core_xfer && (icnt == '0);
  assign frame_done  = sink_xfer && (ocnt == LAST);

  assign p_stopout = out_valid & stopout;
  assign pushout   = out_valid;
  assign firstout  = out_valid && (ocnt == '0);
  assign dout      = out_data;

  assign busy     = (inflight != '0) || (fcnt != 2'd0) || out_valid;
  assign fcnt_nxt = fcnt + {1'b0, in_xfer} - {1'b0, core_xfer};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) fq[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      fcnt   <= 2'd0;
      stopin <= 1'b0;
    end else begin
      if (in_xfer) begin
        fq[wr_ptr] <= {firstin, din};
        wr_ptr     <= ~wr_ptr;
      end
      if (core_xfer) rd_ptr <= ~rd_ptr;
      fcnt   <= fcnt_nxt;
      // registered stop: full next cycle means no more room
      stopin <= (fcnt_nxt == 2'd2);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      icnt      <= '0;
      inflight  <= '0;
      err_in    <= 1'b0;
      frames_in <= '0;
    end else begin
      if (core_xfer) begin
        icnt <= (icnt == LAST) ? '0 : icnt + LW'(1);
        // beat is forwarded as its counted lane either way; only flag it
        if (head_first != (icnt == '0)) err_in <= 1'b1;
        if (icnt == LAST) frames_in <= frames_in + CW'(1);
      end
      if (frame_start && !frame_done)      inflight <= inflight + FW'(1);
      else if (!frame_start && frame_done) inflight <= inflight - FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_data   <= '0;
      ocnt       <= '0;
      err_out    <= 1'b0;
      frames_out <= '0;
    end else begin
      if (!out_valid || sink_xfer) begin
        out_valid <= pout_xfer;
        if (pout_xfer) begin
          out_data  <= p_dout;
          out_first <= p_firstout;
        end
      end
      if (sink_xfer) begin
        ocnt <= (ocnt == LAST) ? '0 : ocnt + LW'(1);
        if (out_first != (ocnt == '0)) err_out <= 1'b1;
        if (ocnt == LAST) frames_out <= frames_out + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_keccak_frame_ctl.sv
// Randomized bench for keccak_frame_ctl: source, core and sink models drive the
// streams while a lane-count reference predicts every output cycle by cycle.
module tb_keccak_frame_ctl;
  localparam int W = 64, LANES = 25, MAXF = 1, CW = 16;

  logic          clk, rst;
  logic          pushin, stopin, firstin;
  logic [W-1:0]  din;
  logic          p_pushin, p_stopin, p_firstin;
  logic [W-1:0]  p_din;
  logic          p_pushout, p_stopout, p_firstout;
  logic [W-1:0]  p_dout;
  logic          pushout, stopout, firstout;
  logic [W-1:0]  dout;
  logic          err_in, err_out, busy;
  logic [CW-1:0] frames_in, frames_out;

  keccak_frame_ctl #(.W(W), .LANES(LANES), .MAX_INFLIGHT(MAXF), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .pushin(pushin), .stopin(stopin), .firstin(firstin), .din(din),
    .p_pushin(p_pushin), .p_stopin(p_stopin), .p_firstin(p_firstin), .p_din(p_din),
    .p_pushout(p_pushout), .p_stopout(p_stopout), .p_firstout(p_firstout), .p_dout(p_dout),
    .pushout(pushout), .stopout(stopout), .firstout(firstout), .dout(dout),
    .err_in(err_in), .err_out(err_out), .frames_in(frames_in), .frames_out(frames_out),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [W-1:0] d; logic f; } beat_t;

  int n_tests = 0, n_fail = 0;
  beat_t in_q[$], core_q[$], out_q[$];
  int src_n, core_n, sink_n;
  bit e_in, e_out, s_pend, c_pend;
  beat_t s_beat;
  int p_push, p_pstop, p_cpush, p_stop, p_flip_in, p_flip_out;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    in_q.delete(); core_q.delete(); out_q.delete();
    src_n = 0; core_n = 0; sink_n = 0;
    e_in = 0; e_out = 0; s_pend = 0; c_pend = 0;
  endtask

  task automatic idle_inputs();
    pushin = 0; firstin = 0; din = '0; p_stopin = 0;
    p_pushout = 0; p_firstout = 0; p_dout = '0; stopout = 0;
  endtask

  task automatic chk_reset(input string ph);
    chk({ph, ".stopin"}, stopin, 0);
    chk({ph, ".p_pushin"}, p_pushin, 0);
    chk({ph, ".p_firstin"}, p_firstin, 1);
    chk({ph, ".p_din"}, p_din, 0);
    chk({ph, ".p_stopout"}, p_stopout, 0);
    chk({ph, ".pushout"}, pushout, 0);
    chk({ph, ".firstout"}, firstout, 0);
    chk({ph, ".dout"}, dout, 0);
    chk({ph, ".err_in"}, err_in, 0);
    chk({ph, ".err_out"}, err_out, 0);
    chk({ph, ".frames_in"}, frames_in, 0);
    chk({ph, ".frames_out"}, frames_out, 0);
    chk({ph, ".busy"}, busy, 0);
  endtask

  task automatic cycle();
    int infl;
    bit gate_e, sx, cx, px, kx;
    beat_t b;
    @(negedge clk);
    // source: a presented beat stays put until it is taken
    if (!s_pend && $urandom_range(99) < p_push) begin
      s_beat.d = {$urandom, $urandom};
      s_beat.f = ((src_n % LANES) == 0) ^ ($urandom_range(99) < p_flip_in);
      s_pend = 1;
    end
    pushin = s_pend; din = s_beat.d; firstin = s_beat.f;
    p_stopin = ($urandom_range(99) < p_pstop);
    if (!c_pend && core_q.size() > 0 && $urandom_range(99) < p_cpush) c_pend = 1;
    p_pushout = c_pend;
    if (c_pend) begin p_dout = core_q[0].d; p_firstout = core_q[0].f; end
    else begin p_dout = '0; p_firstout = 0; end
    stopout = ($urandom_range(99) < p_stop);
    #1;
    // frames started at the core minus frames finished at the sink
    infl   = (core_n + LANES - 1) / LANES - sink_n / LANES;
    gate_e = ((core_n % LANES) == 0) && (infl == MAXF);
    chk("stopin", stopin, in_q.size() == 2);
    chk("p_pushin", p_pushin, (in_q.size() > 0) && !gate_e);
    chk("p_firstin", p_firstin, (core_n % LANES) == 0);
    if (in_q.size() > 0) chk("p_din", p_din, in_q[0].d);
    chk("p_stopout", p_stopout, (out_q.size() > 0) && stopout);
    chk("pushout", pushout, out_q.size() > 0);
    if (out_q.size() > 0) begin
      chk("dout", dout, out_q[0].d);
      chk("firstout", firstout, (sink_n % LANES) == 0);
    end else chk("firstout", firstout, 0);
    chk("err_in", err_in, e_in);
    chk("err_out", err_out, e_out);
    chk("frames_in", frames_in, (core_n / LANES) % (1 << CW));
    chk("frames_out", frames_out, (sink_n / LANES) % (1 << CW));
    chk("busy", busy, (infl > 0) || (in_q.size() > 0) || (out_q.size() > 0));

    sx = pushin && !stopin;
    cx = p_pushin && !p_stopin;
    px = p_pushout && !p_stopout;
    kx = pushout && !stopout;
    if (cx && in_q.size() > 0) begin
      b = in_q.pop_front();
      if (b.f != ((core_n % LANES) == 0)) e_in = 1;
      b.d = p_din;
      b.f = ((core_n % LANES) == 0) ^ ($urandom_range(99) < p_flip_out);
      core_q.push_back(b);
      core_n++;
    end
    if (sx) begin in_q.push_back(s_beat); src_n++; s_pend = 0; end
    if (kx && out_q.size() > 0) begin
      b = out_q.pop_front();
      if (b.f != ((sink_n % LANES) == 0)) e_out = 1;
      sink_n++;
    end
    if (px && core_q.size() > 0) begin
      out_q.push_back(core_q.pop_front());
      c_pend = 0;
    end
  endtask

  task automatic knobs(input int a, input int b, input int c, input int d, input int e, input int f);
    p_push = a; p_pstop = b; p_cpush = c; p_stop = d; p_flip_in = e; p_flip_out = f;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    reset_model();
    #1;
    chk_reset("por");
    repeat (2) @(negedge clk);
    rst = 1;

    knobs(100, 0, 100, 0, 0, 0);       // clean back-to-back frames
    run(300);
    knobs(70, 30, 70, 30, 0, 0);       // random stalls on every port
    run(1500);
    knobs(100, 80, 100, 0, 0, 0);      // heavy core backpressure
    run(400);

    // reset in the middle of a frame
    knobs(100, 0, 100, 0, 0, 0);
    begin
      int t = 0;
      while ((src_n % LANES) != 12 && t < 300) begin cycle(); t++; end
      chk("midframe_reached", (src_n % LANES) == 12, 1);
    end
    @(negedge clk);
    #2 rst = 0;
    #1 chk_reset("mid");
    idle_inputs();
    reset_model();
    repeat (2) @(negedge clk);
    rst = 1;
    run(200);

    knobs(75, 25, 75, 25, 6, 6);       // misaligned firsts on both sides
    run(1500);
    knobs(0, 0, 100, 0, 0, 0);         // let the pipeline empty out
    run(120);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
